// File: rtl/alu_operand_entry.sv
// Front end for the 8-bit ALU board stand: synchronizes switches and keys, debounces
// the keys and loads operand nibbles / toggles mode. Optional macro: ALU_ENTRY_LONG_CLR_EN.
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  input  logic [1:0] key_n,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       mode,
  output logic [3:0] sel,
  output logic       wr_strobe,
  output logic       clr_strobe
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } db_state_e;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("alu_operand_entry: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 2");
  end

  logic [9:0]     sw_meta_q, sw_meta_d;
  logic [9:0]     sw_sync_q, sw_sync_d;
  logic [1:0]     key_meta_q, key_meta_d;
  logic [1:0]     key_sync_q, key_sync_d;

  db_state_e      db_state_q [2];
  db_state_e      db_state_d [2];
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic [1:0]     press_fire;

  logic [7:0]     a_q, a_d;
  logic [7:0]     b_q, b_d;
  logic           mode_q, mode_d;
  logic           wr_q, wr_d;
  logic           long_clr;

  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    key_meta_d = key_n;
    key_sync_d = key_meta_q;
  end

  // Keys are active-low after synchronization; each key owns its own FSM and counter.
  always_comb begin
    press_fire = 2'b00;
    for (int k = 0; k < 2; k++) begin
      db_state_d[k] = db_state_q[k];
      db_cnt_d[k]   = db_cnt_q[k];
      case (db_state_q[k])
        IDLE: begin
          if (!key_sync_q[k]) begin
            db_state_d[k] = PRESS_CHK;
            db_cnt_d[k]   = '0;
          end
        end
        PRESS_CHK: begin
          if (key_sync_q[k]) begin
            db_state_d[k] = IDLE;
            db_cnt_d[k]   = '0;
          end else if (db_cnt_q[k] == CNT_LAST) begin
            db_state_d[k] = PRESSED;
            db_cnt_d[k]   = '0;
            press_fire[k] = 1'b1;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (key_sync_q[k]) begin
            db_state_d[k] = REL_CHK;
            db_cnt_d[k]   = '0;
          end
        end
        REL_CHK: begin
          if (!key_sync_q[k]) begin
            db_state_d[k] = PRESSED;
            db_cnt_d[k]   = '0;
          end else if (db_cnt_q[k] == CNT_LAST) begin
            db_state_d[k] = IDLE;
            db_cnt_d[k]   = '0;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + CNT_W'(1);
          end
        end
        default: begin
          db_state_d[k] = IDLE;
          db_cnt_d[k]   = '0;
        end
      endcase
    end
  end

`ifdef ALU_ENTRY_LONG_CLR_EN
  localparam int               LONG_W    = $clog2(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_done_q, long_done_d;
  logic              clr_q, clr_d;

  // The done flag survives REL_CHK bounces so a single press clears at most once.
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_clr    = 1'b0;
    if (db_state_q[0] == PRESSED && !key_sync_q[0]) begin
      if (!long_done_q) begin
        if (long_cnt_q == LONG_LAST) begin
          long_clr    = 1'b1;
          long_done_d = 1'b1;
        end else begin
          long_cnt_d = long_cnt_q + LONG_W'(1);
        end
      end
    end else begin
      long_cnt_d = '0;
      if (db_state_q[0] == IDLE) begin
        long_done_d = 1'b0;
      end
    end
    clr_d = long_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      clr_q       <= clr_d;
    end
  end

  assign clr_strobe = clr_q;
`else
  assign long_clr   = 1'b0;
  assign clr_strobe = 1'b0;
`endif

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q ^ press_fire[1];
    wr_d   = press_fire[0];
    if (press_fire[0]) begin
      case (sw_sync_q[9:8])
        2'b00:   a_d[3:0] = sw_sync_q[3:0];
        2'b01:   a_d[7:4] = sw_sync_q[3:0];
        2'b10:   b_d[3:0] = sw_sync_q[3:0];
        default: b_d[7:4] = sw_sync_q[3:0];
      endcase
    end
    if (long_clr) begin
      if (sw_sync_q[9]) begin
        b_d = 8'h00;
      end else begin
        a_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= 2'b11;
      key_sync_q <= 2'b11;
      for (int k = 0; k < 2; k++) begin
        db_state_q[k] <= IDLE;
        db_cnt_q[k]   <= '0;
      end
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      mode_q <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      for (int k = 0; k < 2; k++) begin
        db_state_q[k] <= db_state_d[k];
        db_cnt_q[k]   <= db_cnt_d[k];
      end
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      wr_q   <= wr_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign mode      = mode_q;
  assign sel       = sw_sync_q[7:4];
  assign wr_strobe = wr_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Expected values are hand-computed; ALU_ENTRY_LONG_CLR_EN selects the long-press expectations.
module tb_alu_operand_entry;

  localparam int DEB = 4;
  localparam int LNG = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic [1:0] key_n;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       mode;
  logic [3:0] sel;
  logic       wr_strobe;
  logic       clr_strobe;

  int vec_count = 0;
  int miss_count = 0;
  int wr_count = 0;
  int clr_count = 0;
  int wr_base;
  int clr_base;

  alu_operand_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .key_n     (key_n),
    .a_out     (a_out),
    .b_out     (b_out),
    .mode      (mode),
    .sel       (sel),
    .wr_strobe (wr_strobe),
    .clr_strobe(clr_strobe)
  );

  always #5 clk = ~clk;

  // Strobe pulses are tallied so single-action behaviour can be checked over long holds.
  always @(negedge clk) begin
    if (wr_strobe) wr_count++;
    if (clr_strobe) clr_count++;
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [9:0] sw_val, input logic [1:0] key_val);
    sw    = sw_val;
    key_n = key_val;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pressKey(input logic [9:0] sw_val, input logic [1:0] key_val, input int hold);
    applyStimulus(sw_val, key_val);
    waitEdges(hold);
    applyStimulus(sw_val, 2'b11);
    waitEdges(12);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(10'h000, 2'b11);
    waitEdges(3);
    checkOutput("rst_a", 16'(a_out), 16'h00);
    checkOutput("rst_b", 16'(b_out), 16'h00);
    checkOutput("rst_mode", 16'(mode), 16'h0);
    checkOutput("rst_sel", 16'(sel), 16'h0);
    checkOutput("rst_wr", 16'(wr_strobe), 16'h0);
    checkOutput("rst_clr", 16'(clr_strobe), 16'h0);
    rst_n = 1'b1;
    waitEdges(3);

    // Basic write: low nibble of A, action exactly on edge 7.
    wr_base = wr_count;
    applyStimulus(10'h005, 2'b10);
    waitEdges(6);
    checkOutput("basic_a_e6", 16'(a_out), 16'h00);
    checkOutput("basic_wr_e6", 16'(wr_strobe), 16'h0);
    waitEdges(1);
    checkOutput("basic_a_e7", 16'(a_out), 16'h05);
    checkOutput("basic_wr_e7", 16'(wr_strobe), 16'h1);
    waitEdges(1);
    checkOutput("basic_wr_e8", 16'(wr_strobe), 16'h0);
    waitEdges(2);
    applyStimulus(10'h005, 2'b11);
    waitEdges(12);
    checkOutput("basic_wr_cnt", 16'(wr_count - wr_base), 16'd1);

    pressKey(10'h10A, 2'b10, 10);
    checkOutput("high_nib_a", 16'(a_out), 16'hA5);
    checkOutput("high_nib_b", 16'(b_out), 16'h00);

    // sel tracks sw[7:4] two edges later.
    applyStimulus(10'h0F0, 2'b11);
    waitEdges(1);
    checkOutput("sel_e1", 16'(sel), 16'h0);
    waitEdges(1);
    checkOutput("sel_e2", 16'(sel), 16'hF);

    // Bounce on press then on release.
    wr_base = wr_count;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'h003, 2'b10);
      waitEdges(2);
      applyStimulus(10'h003, 2'b11);
      waitEdges(2);
    end
    checkOutput("bounce_none", 16'(wr_count - wr_base), 16'd0);
    applyStimulus(10'h003, 2'b10);
    waitEdges(6);
    checkOutput("bounce_a_e6", 16'(a_out), 16'hA5);
    waitEdges(1);
    checkOutput("bounce_a_e7", 16'(a_out), 16'hA3);
    waitEdges(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(10'h003, 2'b11);
      waitEdges(2);
      applyStimulus(10'h003, 2'b10);
      waitEdges(2);
    end
    applyStimulus(10'h003, 2'b11);
    waitEdges(12);
    checkOutput("bounce_wr_cnt", 16'(wr_count - wr_base), 16'd1);
    checkOutput("bounce_a_end", 16'(a_out), 16'hA3);

    // Three mode toggles.
    pressKey(10'h003, 2'b01, 8);
    checkOutput("mode_1", 16'(mode), 16'h1);
    pressKey(10'h003, 2'b01, 8);
    checkOutput("mode_2", 16'(mode), 16'h0);
    pressKey(10'h003, 2'b01, 8);
    checkOutput("mode_3", 16'(mode), 16'h1);
    checkOutput("mode_a", 16'(a_out), 16'hA3);
    checkOutput("mode_b", 16'(b_out), 16'h00);

    pressKey(10'h303, 2'b10, 10);
    checkOutput("b_high", 16'(b_out), 16'h30);

    // Both keys on the same cycle.
    applyStimulus(10'h207, 2'b00);
    waitEdges(6);
    checkOutput("sim_b_e6", 16'(b_out), 16'h30);
    checkOutput("sim_mode_e6", 16'(mode), 16'h1);
    waitEdges(1);
    checkOutput("sim_b_e7", 16'(b_out), 16'h37);
    checkOutput("sim_mode_e7", 16'(mode), 16'h0);
    waitEdges(3);
    applyStimulus(10'h207, 2'b11);
    waitEdges(12);

    pressKey(10'h005, 2'b10, 10);
    checkOutput("pre_rst_a", 16'(a_out), 16'hA5);
    pressKey(10'h005, 2'b01, 8);
    checkOutput("pre_rst_mode", 16'(mode), 16'h1);

    // Reset while KEY[0] is in PRESS_CHK and still held afterwards.
    applyStimulus(10'h00E, 2'b10);
    waitEdges(4);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_a", 16'(a_out), 16'h00);
    checkOutput("midrst_b", 16'(b_out), 16'h00);
    checkOutput("midrst_mode", 16'(mode), 16'h0);
    waitEdges(2);
    rst_n = 1'b1;
    wr_base = wr_count;
    waitEdges(6);
    checkOutput("postrst_a_e6", 16'(a_out), 16'h00);
    waitEdges(1);
    checkOutput("postrst_a_e7", 16'(a_out), 16'h0E);
    checkOutput("postrst_wr_e7", 16'(wr_strobe), 16'h1);
    waitEdges(3);
    applyStimulus(10'h00E, 2'b11);
    waitEdges(12);
    checkOutput("postrst_wr_cnt", 16'(wr_count - wr_base), 16'd1);

    // Long hold on KEY[0] with B selected.
    pressKey(10'h303, 2'b10, 10);
    pressKey(10'h20C, 2'b10, 10);
    checkOutput("long_pre_b", 16'(b_out), 16'h3C);
    clr_base = clr_count;
    applyStimulus(10'h200, 2'b10);
    waitEdges(6 + LNG);
    checkOutput("long_b_before", 16'(b_out), 16'h30);
    waitEdges(1);
`ifdef ALU_ENTRY_LONG_CLR_EN
    checkOutput("long_b_clr", 16'(b_out), 16'h00);
    checkOutput("long_clr_pulse", 16'(clr_strobe), 16'h1);
`else
    checkOutput("long_b_clr", 16'(b_out), 16'h30);
    checkOutput("long_clr_pulse", 16'(clr_strobe), 16'h0);
`endif
    waitEdges(1);
    checkOutput("long_clr_after", 16'(clr_strobe), 16'h0);
    waitEdges(12);
    applyStimulus(10'h200, 2'b11);
    waitEdges(14);
`ifdef ALU_ENTRY_LONG_CLR_EN
    checkOutput("long_clr_cnt", 16'(clr_count - clr_base), 16'd1);
    checkOutput("long_b_end", 16'(b_out), 16'h00);
`else
    checkOutput("long_clr_cnt", 16'(clr_count - clr_base), 16'd0);
    checkOutput("long_b_end", 16'(b_out), 16'h30);
`endif
    checkOutput("long_a_end", 16'(a_out), 16'h0E);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Clocked front end for the 8-bit ALU board stand.
- Synchronizes SW and active-low KEY inputs, debounces the keys, and writes switch nibbles into operand registers A and B on each confirmed KEY[0] press.
- Toggles MATH/LOGIC mode on each confirmed KEY[1] press.
- Outputs drive the ALU a/b/mode/sel inputs and the HEX operand displays directly; raw key edges never clock any register.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable synced samples required to accept a press or release (1 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, hold time for the long-press clear; only used with the optional feature.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- sw  input  10  raw switches; [9] operand select (0=A, 1=B), [8] nibble select (0=low, 1=high), [7:4] opcode, [3:0] data nibble
- key_n  input  2  raw push buttons, low when pressed; [0]=write, [1]=mode toggle
- a_out  output  8  operand A register
- b_out  output  8  operand B register
- mode  output  1  0=MATH, 1=LOGIC
- sel  output  4  synchronized sw[7:4]
- wr_strobe  output  1  one-cycle pulse on the edge an operand nibble is written
- clr_strobe  output  1  one-cycle pulse on long-press clear; constant 0 when the feature is compiled out

Behaviour:
- **Reset.** Clock is clk; reset is rst_n, asynchronous, active-low.
  - During reset: a_out=0, b_out=0, mode=0, sel=0, wr_strobe=0, clr_strobe=0.
  - sw synchronizer flops reset to 0; key synchronizer flops reset to 1 (released).
  - All debounce FSMs go to IDLE and all counters to 0.
- **Synchronization.** sw and key_n each pass through 2-flop synchronizers. All logic uses only the synced values. sel equals synced sw[7:4], 2 cycles after sw.
- **Debounce FSM.** One independent FSM and counter per key.
  - IDLE: on synced key low, go to PRESS_CHK with cnt=0.
  - PRESS_CHK: synced key high returns to IDLE. Otherwise cnt increments. When cnt==DEBOUNCE_CYCLES-1 and key is still low, the next edge enters PRESSED and fires the press action on that same edge.
  - PRESSED: on synced key high, go to REL_CHK with cnt=0.
  - REL_CHK: synced key low returns to PRESSED with no new action. cnt==DEBOUNCE_CYCLES-1 with key still high returns to IDLE.
- **Latency.** Key held stably low from the first sampling edge gives the action at edge DEBOUNCE_CYCLES+3. Example: 7 edges for DEBOUNCE_CYCLES=4. Exactly one action per accepted press, regardless of hold time or bounce.
- **KEY[0] action.**
  - Target operand and nibble are chosen by synced sw[9:8] at the action edge.
  - The selected nibble is loaded with synced sw[3:0]; the other nibble and the other operand are unchanged.
  - wr_strobe is high for the following cycle only.
- **KEY[1] action.** mode inverts.
- **Simultaneous events.** KEY[0] and KEY[1] actions on the same edge both apply. Switch changes during PRESS_CHK are ignored; only the value at the action edge matters.
- **Reset mid-press.** Registers clear immediately. A key still held after reset release is treated as a new press: one action after the full debounce.
- **Counter width.** Counters are sized by $clog2 of the parameter and must not wrap within a state.

Optional Feature:
- Macro: ALU_ENTRY_LONG_CLR_EN.
- **Defined.** A second counter runs while the KEY[0] FSM is in PRESSED.
  - When it reaches LONG_CYCLES-1, the operand chosen by synced sw[9] at that edge is cleared to 0x00, and clr_strobe pulses for one cycle.
  - At most one clear per press. The counter resets on leaving PRESSED.
  - The nibble write from the same press has already occurred and is overwritten by the clear.
- **Undefined.** No long counter is built; clr_strobe is tied 0. Port list is unchanged.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
- **Basic writes.** rst_n low then high. sw=0x005, key_n[0] low for 10 cycles -> a_out=0x05 at edge 7 after press, wr_strobe high exactly 1 cycle. Then sw=0x10A, press -> a_out=0xA5, b_out unchanged 0x00.
- **Bounce rejection.** key_n[0] toggling low/high every 2 cycles for 20 cycles, then stable low 10 cycles -> exactly one write, at stable-low edge 7. Bounce during release -> no extra write.
- **Mode and B writes.** Three clean KEY[1] presses -> mode 0→1→0→1; a_out/b_out unchanged. sw=0x303 plus KEY[0] press -> b_out=0x30.
- **Simultaneous presses.** KEY[0] and KEY[1] pressed on the same cycle with sw=0x207 -> b_out[3:0]=7 and mode toggles on the same edge.
- **Reset mid-press.** rst_n pulsed low during PRESS_CHK with a_out=0xA5 -> a_out=0, mode=0 immediately. Key still held after release -> one write 7 edges after rst_n rises.
- **Long-press clear (macro defined).** b_out=0x3C, sw[9]=1, hold KEY[0] for 40 cycles -> clr_strobe one pulse, b_out=0x00, single clear. Macro undefined -> clr_strobe stays 0.
